// File: rtl/fir_coeff_loader_pkg.sv
// Shared types and helpers for the FIR coefficient loader.
// Loader FSM states and a constant clog2.
package fir_coeff_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/fir_coeff_loader_bank.sv
// Shadow and active coefficient banks for fir_coeff_loader.
// Shadow is written word-by-word; active is swapped in as a whole.
module fir_coeff_loader_bank
   import fir_coeff_loader_pkg::*;
#(
   parameter int BITWIDTH = 16,
   parameter int N        = 16,
   parameter int IDXW     = 4,
   parameter bit MIRROR   = 1'b0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  we,
   input  logic [IDXW-1:0]       widx,
   input  logic [BITWIDTH-1:0]   wdata,
   input  logic                  swap,
   output logic [BITWIDTH*N-1:0] coeffs
);

   logic [BITWIDTH-1:0] shadow_q [N];
   logic [BITWIDTH-1:0] active_q [N];
   logic [IDXW-1:0]     midx;

   assign midx = IDXW'(N - 1) - widx;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < N; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (we && (IDXW'(i) == widx ||
                       (MIRROR && IDXW'(i) == midx)))
               shadow_q[i] <= wdata;
         end
         if (swap) active_q <= shadow_q;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_tap
      assign coeffs[BITWIDTH*g +: BITWIDTH] = active_q[g];
   end

endmodule

// File: rtl/fir_coeff_loader.sv
// Serial FIR coefficient loader with atomic shadow->active commit.
// Define FIR_COEFF_SYMMETRIC_EN for mirrored linear-phase loading.
module fir_coeff_loader
   import fir_coeff_loader_pkg::*;
#(
   parameter int BITWIDTH = 16,
   parameter int N        = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  load_start,
   input  logic [BITWIDTH-1:0]   coeff_in,
   input  logic                  coeff_valid,
   output logic                  coeff_ready,
   input  logic                  commit,
   output logic [BITWIDTH*N-1:0] coeffs,
   output logic                  coeff_update,
   output logic                  busy,
   output logic                  commit_err
);

   localparam int IDXW = clog2(N);
`ifdef FIR_COEFF_SYMMETRIC_EN
   localparam int NLOAD  = (N + 1) / 2;
   localparam bit MIRROR = 1'b1;
`else
   localparam int NLOAD  = N;
   localparam bit MIRROR = 1'b0;
`endif
   localparam logic [IDXW-1:0] LAST = IDXW'(NLOAD - 1);

   state_e          state_q;
   logic [IDXW-1:0] idx_q;
   logic            ready_q;
   logic            busy_q;
   logic            upd_q;
   logic            err_q;
   logic            xfer;
   logic            we;
   logic            swap;

   assign xfer = coeff_valid & ready_q;
   // restart wins over a word arriving the same cycle
   assign we   = xfer & ~load_start;
   assign swap = commit & (state_q == ST_FULL);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         upd_q <= swap;
         err_q <= commit & (state_q != ST_FULL);
         unique case (state_q)
            ST_IDLE: begin
               if (load_start) begin
                  state_q <= ST_LOAD;
                  idx_q   <= '0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (load_start) begin
                  idx_q <= '0;
               end else if (xfer) begin
                  if (idx_q == LAST) begin
                     state_q <= ST_FULL;
                     ready_q <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            ST_FULL: begin
               if (load_start) begin
                  state_q <= ST_LOAD;
                  idx_q   <= '0;
                  ready_q <= 1'b1;
               end else if (commit) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               idx_q   <= '0;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   fir_coeff_loader_bank #(
      .BITWIDTH (BITWIDTH),
      .N        (N),
      .IDXW     (IDXW),
      .MIRROR   (MIRROR)
   ) u_bank (
      .clk    (clk),
      .resetn (resetn),
      .we     (we),
      .widx   (idx_q),
      .wdata  (coeff_in),
      .swap   (swap),
      .coeffs (coeffs)
   );

   assign coeff_ready  = ready_q;
   assign busy         = busy_q;
   assign coeff_update = upd_q;
   assign commit_err   = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized self-checking bench for fir_coeff_loader.
// Honors FIR_COEFF_SYMMETRIC_EN for the mirrored-load mode.
module tb_fir_coeff_loader;

   localparam int BW = 16;
   localparam int N  = 16;
`ifdef FIR_COEFF_SYMMETRIC_EN
   localparam int NLOAD = (N + 1) / 2;
   localparam bit SYM   = 1'b1;
`else
   localparam int NLOAD = N;
   localparam bit SYM   = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          load_start = 1'b0;
   logic [BW-1:0] coeff_in = '0;
   logic          coeff_valid = 1'b0;
   logic          coeff_ready;
   logic          commit = 1'b0;
   logic [BW*N-1:0] coeffs;
   logic          coeff_update;
   logic          busy;
   logic          commit_err;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // reference model: mode 0 idle, 1 loading, 2 full
   int            m_mode = 0;
   int            m_cnt  = 0;
   logic [BW-1:0] m_sh  [N];
   logic [BW-1:0] m_act [N];
   logic          m_upd = 1'b0;
   logic          m_err = 1'b0;

   fir_coeff_loader #(.BITWIDTH(BW), .N(N)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .load_start   (load_start),
      .coeff_in     (coeff_in),
      .coeff_valid  (coeff_valid),
      .coeff_ready  (coeff_ready),
      .commit       (commit),
      .coeffs       (coeffs),
      .coeff_update (coeff_update),
      .busy         (busy),
      .commit_err   (commit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [BW*N-1:0] act,
                      input logic [BW*N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [BW*N-1:0] pack_act();
      logic [BW*N-1:0] v;
      for (int i = 0; i < N; i++) v[BW*i +: BW] = m_act[i];
      return v;
   endfunction

   task automatic model_step(input logic rn, input logic ls,
                             input logic v, input logic [BW-1:0] d,
                             input logic cm);
      if (!rn) begin
         m_mode = 0; m_cnt = 0; m_upd = 0; m_err = 0;
         for (int i = 0; i < N; i++) begin
            m_sh[i] = '0; m_act[i] = '0;
         end
         return;
      end
      m_upd = 0; m_err = 0;
      if (cm) begin
         if (m_mode == 2) begin
            for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
            m_upd = 1;
         end else m_err = 1;
      end
      if (ls) begin
         m_mode = 1; m_cnt = 0;
      end else if (m_mode == 1 && v) begin
         m_sh[m_cnt] = d;
         if (SYM) m_sh[N-1-m_cnt] = d;
         m_cnt++;
         if (m_cnt == NLOAD) m_mode = 2;
      end else if (m_mode == 2 && cm) begin
         m_mode = 0;
      end
   endtask

   task automatic cyc(input logic rn, input logic ls, input logic v,
                      input logic [BW-1:0] d, input logic cm);
      resetn = rn; load_start = ls; coeff_valid = v;
      coeff_in = d; commit = cm;
      @(posedge clk);
      model_step(rn, ls, v, d, cm);
      #1;
   endtask

   task automatic idle_cyc();
      cyc(1, 0, 0, BW'($urandom), 0);
   endtask

   task automatic send(input int n, input int base, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps) cyc(1, 0, 0, BW'($urandom), 0);
         cyc(1, 0, 1, BW'(base + k), 0);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("coeffs", coeffs, pack_act());
         chk("coeff_ready", {255'd0, coeff_ready},
             {255'd0, m_mode == 1});
         chk("busy", {255'd0, busy}, {255'd0, m_mode != 0});
         chk("coeff_update", {255'd0, coeff_update}, {255'd0, m_upd});
         chk("commit_err", {255'd0, commit_err}, {255'd0, m_err});
      end
   end

   logic [BW*N-1:0] exp_v;
   logic [BW*N-1:0] keep_v;

   initial begin
      cyc(0, 0, 0, '0, 0);
      cyc(0, 0, 0, '0, 0);
      cmp_en = 1'b1;
      chk("reset coeffs", coeffs, '0);
      chk("reset ready", {255'd0, coeff_ready}, '0);
      chk("reset busy", {255'd0, busy}, '0);
      chk("reset pulses", {254'd0, coeff_update, commit_err}, '0);
      idle_cyc();

      // full load with valid held
      cyc(1, 1, 0, '0, 0);
      send(NLOAD, 0, 0);
      chk("full busy", {255'd0, busy}, 256'd1);
      chk("full ready", {255'd0, coeff_ready}, '0);
      cyc(1, 0, 0, '0, 1);
      chk("commit upd", {255'd0, coeff_update}, 256'd1);
      if (!SYM) begin
         for (int i = 0; i < N; i++) exp_v[BW*i +: BW] = BW'(i);
         chk("taps 0..15", coeffs, exp_v);
      end
      idle_cyc();
      chk("upd one cycle", {255'd0, coeff_update}, '0);
      chk("back idle", {255'd0, busy}, '0);

      // gaps, early commit
      keep_v = coeffs;
      cyc(1, 1, 0, '0, 0);
      send(7, 100, 1);
      cyc(1, 0, 0, '0, 1);
      chk("early err", {255'd0, commit_err}, 256'd1);
      chk("early keep", coeffs, keep_v);
      send(NLOAD - 7, 107, 1);
      cyc(1, 0, 1, 16'h5555, 0);
      cyc(1, 0, 0, '0, 1);
      if (!SYM) begin
         for (int i = 0; i < N; i++) exp_v[BW*i +: BW] = BW'(100 + i);
         chk("gap taps", coeffs, exp_v);
      end

      // restart, then load_start with commit in FULL
      cyc(1, 1, 0, '0, 0);
      for (int k = 0; k < 5; k++) cyc(1, 0, 1, 16'h7FFF, 0);
      cyc(1, 1, 1, 16'h7FFF, 0);
      send(NLOAD, -32768, 0);
      cyc(1, 1, 0, '0, 1);
      chk("ls+commit upd", {255'd0, coeff_update}, 256'd1);
      chk("ls+commit busy", {255'd0, busy}, 256'd1);
      if (!SYM) begin
         for (int i = 0; i < N; i++)
            exp_v[BW*i +: BW] = BW'(-32768 + i);
         chk("restart taps", coeffs, exp_v);
      end

`ifdef FIR_COEFF_SYMMETRIC_EN
      cyc(1, 1, 0, '0, 0);
      send(8, 1, 0);
      chk("sym full", {255'd0, busy && !coeff_ready}, 256'd1);
      cyc(1, 0, 0, '0, 1);
      for (int i = 0; i < N; i++)
         exp_v[BW*i +: BW] = BW'(i < 8 ? i + 1 : 16 - i);
      chk("sym taps", coeffs, exp_v);
`endif

      // randomized traffic incl. occasional reset
      for (int t = 0; t < 1500; t++) begin
         cyc($urandom_range(0, 299) != 0,
             $urandom_range(0, 24) == 0,
             $urandom_range(0, 2) != 0,
             BW'($urandom),
             $urandom_range(0, 5) == 0);
      end
      idle_cyc();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
